// File: rtl/wfg_capture_mem_if.sv
// AXI-Stream sample channel between a wfg core (master) and the capture memory (slave).
interface wfg_capture_mem_if #(
   parameter int DATA_W = 32
);
   logic              wfg_axis_tready_o;
   logic              wfg_axis_tvalid_i;
   logic [DATA_W-1:0] wfg_axis_tdata_i;

   modport master (
      input  wfg_axis_tready_o,
      output wfg_axis_tvalid_i,
      output wfg_axis_tdata_i
   );

   modport slave (
      output wfg_axis_tready_o,
      input  wfg_axis_tvalid_i,
      input  wfg_axis_tdata_i
   );
endinterface

// File: rtl/wfg_capture_mem.sv
// AXIS sink writing 32-bit samples into an SRAM write port, stepping START..END by INC.
// Define WFG_CAPTURE_MEM_WRAP_EN for a ring-buffer build that restarts at START instead of stopping.
module wfg_capture_mem #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   wfg_capture_mem_if.slave     axis,
   input  logic                 ctrl_en_q_i,
   input  logic [15:0]          start_val_q_i,
   input  logic [15:0]          end_val_q_i,
   input  logic [7:0]           inc_val_q_i,
   output logic                 done_o,
   output logic [15:0]          count_o,
   output logic                 csb0,
   output logic                 web0,
   output logic [3:0]           wmask0,
   output logic [ADDR_W-1:0]    addr0,
   output logic [DATA_W-1:0]    din0
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_WRITE, ST_DONE} state_e;

   state_e              state_q, state_d;
   logic [15:0]         cur_addr_q, cur_addr_d;
   logic [15:0]         count_q, count_d;
   logic                done_q, done_d;
   logic                csb_q, csb_d;
   logic                web_q, web_d;
   logic [3:0]          wmask_q, wmask_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic [16:0]         nxt;
   logic                end_hit;
   logic                tready;

   // Ready is gated by enable so a disabling cycle in ST_WAIT can never complete a handshake.
   assign tready                 = (state_q == ST_WAIT) && ctrl_en_q_i;
   assign axis.wfg_axis_tready_o = tready;

   assign nxt     = {1'b0, cur_addr_q} + {9'd0, inc_val_q_i};
   assign end_hit = nxt > {1'b0, end_val_q_i};

   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      count_d    = count_q;
      done_d     = done_q;
      csb_d      = csb_q;
      web_d      = web_q;
      wmask_d    = wmask_q;
      addr_d     = addr_q;
      din_d      = din_q;
      case (state_q)
         ST_IDLE: begin
            cur_addr_d = start_val_q_i;
            count_d    = 16'd0;
            done_d     = 1'b0;
            if (ctrl_en_q_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (!ctrl_en_q_i) begin
               state_d = ST_IDLE;
            end else if (axis.wfg_axis_tvalid_i) begin
               din_d   = axis.wfg_axis_tdata_i;
               addr_d  = cur_addr_q[ADDR_W-1:0];
               csb_d   = 1'b0;
               web_d   = 1'b0;
               wmask_d = 4'hF;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            csb_d   = 1'b1;
            web_d   = 1'b1;
            wmask_d = 4'h0;
            count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            if (!ctrl_en_q_i) begin
               state_d = ST_IDLE;
            end else if (end_hit) begin
`ifdef WFG_CAPTURE_MEM_WRAP_EN
               cur_addr_d = start_val_q_i;
               state_d    = ST_WAIT;
`else
               done_d     = 1'b1;
               state_d    = ST_DONE;
`endif
            end else begin
               cur_addr_d = nxt[15:0];
               state_d    = ST_WAIT;
            end
         end
         ST_DONE: begin
            if (!ctrl_en_q_i) begin
               done_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cur_addr_q <= 16'd0;
         count_q    <= 16'd0;
         done_q     <= 1'b0;
         csb_q      <= 1'b1;
         web_q      <= 1'b1;
         wmask_q    <= 4'h0;
         addr_q     <= '0;
         din_q      <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         count_q    <= count_d;
         done_q     <= done_d;
         csb_q      <= csb_d;
         web_q      <= web_d;
         wmask_q    <= wmask_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
      end
   end

   // In the wrap build done_d is never raised, so done_o stays tied low.
   assign done_o  = done_q;
   assign count_o = count_q;
   assign csb0    = csb_q;
   assign web0    = web_q;
   assign wmask0  = wmask_q;
   assign addr0   = addr_q;
   assign din0    = din_q;

endmodule

// File: tb/tb_wfg_capture_mem.sv
// Randomized bench for wfg_capture_mem against an address-sequence reference model.
module tb_wfg_capture_mem;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                ctrl_en = 1'b0;
   logic [15:0]         start_val = '0;
   logic [15:0]         end_val = '0;
   logic [7:0]          inc_val = '0;
   logic                done_o;
   logic [15:0]         count_o;
   logic                csb0, web0;
   logic [3:0]          wmask0;
   logic [ADDR_W-1:0]   addr0;
   logic [DATA_W-1:0]   din0;

   wfg_capture_mem_if #(.DATA_W(DATA_W)) axis ();

   wfg_capture_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .axis          (axis),
      .ctrl_en_q_i   (ctrl_en),
      .start_val_q_i (start_val),
      .end_val_q_i   (end_val),
      .inc_val_q_i   (inc_val),
      .done_o        (done_o),
      .count_o       (count_o),
      .csb0          (csb0),
      .web0          (web0),
      .wmask0        (wmask0),
      .addr0         (addr0),
      .din0          (din0)
   );

   int n_cmp = 0;
   int n_fail = 0;
   longint cyc = 0;

   int unsigned wr_addr[$], wr_data[$], wr_mask[$];
   longint      wr_cyc[$];
   int unsigned exp_addr[$], exp_data[$];
   bit          exp_done;

   // SRAM-side observer: a write lands whenever both strobes are low at a rising edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && !csb0 && !web0) begin
         wr_addr.push_back(int'(addr0));
         wr_data.push_back(din0);
         wr_mask.push_back(int'(wmask0));
         wr_cyc.push_back(cyc);
      end
   end

   // Address for each successive accepted sample, derived from START/END/INC rules.
   function automatic void build_model(int unsigned s, int unsigned e, int unsigned inc, int n);
      int unsigned a;
      exp_addr.delete();
      exp_done = 1'b0;
      a = s;
      for (int k = 0; k < n; k++) begin
         exp_addr.push_back(a % (1 << ADDR_W));
         if (a + inc > e) begin
`ifdef WFG_CAPTURE_MEM_WRAP_EN
            a = s;
`else
            exp_done = 1'b1;
            break;
`endif
         end else begin
            a = a + inc;
         end
      end
   endfunction

   task automatic drive(input int n, input bit gaps, output int acc);
      acc = 0;
      for (int k = 0; k < n; k++) begin
         int unsigned d;
         bit got;
         int budget;
         d = $urandom;
         got = 1'b0;
         budget = 0;
         while (!got && budget < 40) begin
            @(negedge clk);
            axis.wfg_axis_tvalid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            axis.wfg_axis_tdata_i  = axis.wfg_axis_tvalid_i ? d : $urandom;
            @(posedge clk);
            if (axis.wfg_axis_tvalid_i && axis.wfg_axis_tready_o) got = 1'b1;
            budget++;
         end
         if (!got) break;
         exp_data.push_back(d);
         acc++;
      end
      @(negedge clk);
      axis.wfg_axis_tvalid_i = 1'b0;
   endtask

   task automatic run_capture(input string name, input int unsigned s, input int unsigned e,
                              input int unsigned inc, input int n, input bit gaps, input bit chk_gap);
      int acc;
      wr_addr.delete(); wr_data.delete(); wr_mask.delete(); wr_cyc.delete();
      exp_data.delete();
      build_model(s, e, inc, n);
      @(negedge clk);
      start_val = 16'(s); end_val = 16'(e); inc_val = 8'(inc);
      ctrl_en = 1'b1;
      drive(n, gaps, acc);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (acc !== exp_addr.size()) begin
         n_fail++; $display("FAIL %s accepted: got %0d want %0d", name, acc, exp_addr.size());
      end
      n_cmp++;
      if (wr_addr.size() !== exp_addr.size()) begin
         n_fail++; $display("FAIL %s writes: got %0d want %0d", name, wr_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < wr_addr.size() && i < exp_data.size(); i++) begin
         n_cmp++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i] || wr_mask[i] !== 4'hF) begin
            n_fail++;
            $display("FAIL %s write[%0d]: got a=%0h d=%0h m=%0h want a=%0h d=%0h m=f",
                     name, i, wr_addr[i], wr_data[i], wr_mask[i], exp_addr[i], exp_data[i]);
         end
         if (chk_gap && i > 0) begin
            n_cmp++;
            if (wr_cyc[i] - wr_cyc[i-1] !== 2) begin
               n_fail++; $display("FAIL %s spacing[%0d]: got %0d want 2", name, i, wr_cyc[i] - wr_cyc[i-1]);
            end
         end
      end
      n_cmp++;
      if (count_o !== 16'(exp_addr.size())) begin
         n_fail++; $display("FAIL %s count_o: got %0d want %0d", name, count_o, exp_addr.size());
      end
      n_cmp++;
      if (done_o !== exp_done) begin
         n_fail++; $display("FAIL %s done_o: got %0b want %0b", name, done_o, exp_done);
      end
      if (exp_done) begin
         repeat (2) @(negedge clk);
         n_cmp++;
         if (axis.wfg_axis_tready_o !== 1'b0 || done_o !== 1'b1) begin
            n_fail++; $display("FAIL %s hold_done: got tready=%0b done=%0b want 0 1", name, axis.wfg_axis_tready_o, done_o);
         end
      end
      ctrl_en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      axis.wfg_axis_tvalid_i = 1'b0;
      axis.wfg_axis_tdata_i  = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (axis.wfg_axis_tready_o !== 1'b0 || csb0 !== 1'b1 || web0 !== 1'b1 || wmask0 !== 4'h0) begin
         n_fail++; $display("FAIL reset strobes: got tready=%0b csb=%0b web=%0b m=%0h want 0 1 1 0",
                            axis.wfg_axis_tready_o, csb0, web0, wmask0);
      end
      n_cmp++;
      if (addr0 !== '0 || din0 !== '0 || done_o !== 1'b0 || count_o !== 16'd0) begin
         n_fail++; $display("FAIL reset data: got a=%0h d=%0h done=%0b cnt=%0d want 0 0 0 0",
                            addr0, din0, done_o, count_o);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_capture("basic", 0, 3, 1, 4, 1'b0, 1'b1);
   endtask

   task automatic test_stride();
      run_capture("stride", 2, 9, 3, 4, 1'b0, 1'b1);
      run_capture("start_gt_end", 30, 5, 1, 3, 1'b0, 1'b0);
      run_capture("inc_zero", 7, 9, 0, 5, 1'b0, 1'b0);
      run_capture("high_bits", 1030, 1045, 4, 5, 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      run_capture("wrap", 4, 5, 1, 5, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      for (int it = 0; it < 5; it++) begin
         int unsigned s, e, inc;
         s = $urandom_range(0, 60);
         e = s + $urandom_range(0, 40);
         inc = $urandom_range(0, 6);
         run_capture("gaps", s, e, inc, $urandom_range(3, 12), 1'b1, 1'b0);
      end
   endtask

   task automatic test_disable_mid_write();
      int unsigned d;
      bit got;
      wr_addr.delete(); wr_data.delete(); wr_mask.delete(); wr_cyc.delete();
      d = $urandom;
      got = 1'b0;
      @(negedge clk);
      start_val = 16'd10; end_val = 16'd20; inc_val = 8'd2;
      ctrl_en = 1'b1;
      axis.wfg_axis_tvalid_i = 1'b1;
      axis.wfg_axis_tdata_i  = d;
      for (int b = 0; b < 10 && !got; b++) begin
         @(posedge clk);
         if (axis.wfg_axis_tready_o) got = 1'b1;
      end
      @(negedge clk);
      ctrl_en = 1'b0;
      axis.wfg_axis_tvalid_i = 1'b0;
      n_cmp++;
      if (!got || csb0 !== 1'b0 || addr0 !== 10'd10 || din0 !== d) begin
         n_fail++; $display("FAIL disable in_flight: got hs=%0b csb=%0b a=%0h d=%0h want 1 0 a %0h",
                            got, csb0, addr0, din0, d);
      end
      @(negedge clk);
      n_cmp++;
      if (wr_addr.size() !== 1 || csb0 !== 1'b1 || count_o !== 16'd1) begin
         n_fail++; $display("FAIL disable completed: got writes=%0d csb=%0b cnt=%0d want 1 1 1",
                            wr_addr.size(), csb0, count_o);
      end
      @(negedge clk);
      n_cmp++;
      if (count_o !== 16'd0 || axis.wfg_axis_tready_o !== 1'b0) begin
         n_fail++; $display("FAIL disable idle: got cnt=%0d tready=%0b want 0 0", count_o, axis.wfg_axis_tready_o);
      end
      run_capture("restart", 10, 20, 2, 2, 1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stride();
      test_wrap();
      test_backpressure();
      test_disable_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
